// File: rtl/mdu_div_seq_if.sv
// Divide handshake between the MDU (master) and the sequential divider (slave).
// Carries operands, request/abort controls and the registered result/ready pair.
interface mdu_div_seq_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div;
    logic [WIDTH-1:0]       opdata1;
    logic [WIDTH-1:0]       opdata2;
    logic                   start;
    logic                   annul;
    logic [2*WIDTH-1:0]     result;
    logic                   ready;

    modport master (
        output signed_div,
        output opdata1,
        output opdata2,
        output start,
        output annul,
        input  result,
        input  ready
    );

    modport slave (
        input  signed_div,
        input  opdata1,
        input  opdata2,
        input  start,
        input  annul,
        output result,
        output ready
    );
endinterface

// File: rtl/mdu_div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned,
// returning {remainder, quotient} with a single-cycle ready pulse.
module mdu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdu_div_seq_if.slave  div_if
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    logic               r_signed;
    logic               r_sign1;
    logic               r_sign2;
    logic [WIDTH-1:0]   r_dividend_raw;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_op1_abs;
    logic [WIDTH-1:0]   w_op2_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_ok;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_div_zero;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_if.start && !div_if.annul) begin
                    w_load       = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (div_if.annul) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                if (!div_if.annul) begin
                    w_finish = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Magnitudes are only taken for signed requests; DIVU operands pass through raw.
    assign w_op1_abs = (div_if.signed_div && div_if.opdata1[WIDTH-1]) ? -div_if.opdata1
                                                                       : div_if.opdata1;
    assign w_op2_abs = (div_if.signed_div && div_if.opdata2[WIDTH-1]) ? -div_if.opdata2
                                                                       : div_if.opdata2;

    // The shifted remainder is below twice the divisor, so W+1 bits hold the trial exactly.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_trial_ok = ~w_trial[WIDTH];

    assign w_neg_q    = r_signed & (r_sign1 ^ r_sign2);
    assign w_neg_r    = r_signed & r_sign1;
    assign w_quo_fix  = w_neg_q ? -r_quo : r_quo;
    assign w_rem_fix  = w_neg_r ? -r_rem : r_rem;
    assign w_div_zero = (r_divisor == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_signed       <= 1'b0;
            r_sign1        <= 1'b0;
            r_sign2        <= 1'b0;
            r_dividend_raw <= '0;
            r_divisor      <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_ready        <= 1'b0;
        end else begin
            r_ready <= w_finish;
            if (w_load) begin
                r_signed       <= div_if.signed_div;
                r_sign1        <= div_if.opdata1[WIDTH-1];
                r_sign2        <= div_if.opdata2[WIDTH-1];
                r_dividend_raw <= div_if.opdata1;
                r_divisor      <= w_op2_abs;
                r_rem          <= '0;
                r_quo          <= w_op1_abs;
                r_cnt          <= '0;
            end
            if (w_step) begin
                r_rem <= w_trial_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                // A zero divisor returns the dividend exactly as presented, never sign-corrected.
                r_result <= w_div_zero ? {r_dividend_raw, {WIDTH{1'b1}}}
                                       : {w_rem_fix, w_quo_fix};
            end
        end
    end

    assign div_if.result = r_result;
    assign div_if.ready  = r_ready;
endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: directed corner cases plus random operands,
// checked against an arithmetic reference model of DIV/DIVU.
module tb_mdu_div_seq;
    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [2*W-1:0] last_result = '0;

    mdu_div_seq_if #(.WIDTH(W)) bus ();

    mdu_div_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] observed,
                         input logic [2*W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer division semantics, truncating toward zero.
    function automatic logic [2*W-1:0] ref_div(input bit sd, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return {a, {W{1'b1}}};
        if (sd) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (bus.ready) seen++;
        end
        check(tag, 2*W'(seen), '0);
    endtask

    // Issue one request, scramble the inputs after the sampling edge, check latency/result/pulse.
    task automatic run_op(input string tag, input bit sd, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int n;
        logic [2*W-1:0] exp_r;
        exp_r          = ref_div(sd, a, b);
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = 1'($urandom);
        wait_ready(n);
        check({tag, "_latency"}, 2*W'(n), 2*W'(LATENCY));
        check({tag, "_result"}, bus.result, exp_r);
        tick();
        check({tag, "_pulse"}, 2*W'(bus.ready), '0);
        last_result = exp_r;
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2*W-1:0] exp_a;
        logic [2*W-1:0] exp_b;

        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        rst            = 1'b0;
        repeat (3) tick();
        check("reset_ready", 2*W'(bus.ready), '0);
        check("reset_result", bus.result, '0);
        rst = 1'b1;
        tick();

        run_op("u_100_7", 1'b0, 32'd100, 32'd7);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u_div0", 1'b0, 32'h1234_5678, 32'h0);
        run_op("s_div0_neg", 1'b1, 32'h8765_4321, 32'h0);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), 1'($urandom), ra, rb);
        end

        // Annul in the middle of BUSY: no ready, result kept, then a clean 50/5.
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        expect_quiet("annul_busy_quiet", 40);
        check("annul_busy_result", bus.result, last_result);
        run_op("u_50_5", 1'b0, 32'd50, 32'd5);

        // Annul in the DONE cycle suppresses the result.
        bus.opdata1 = 32'd77;
        bus.opdata2 = 32'd4;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (W) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        check("annul_done_ready", 2*W'(bus.ready), '0);
        expect_quiet("annul_done_quiet", 5);
        check("annul_done_result", bus.result, last_result);

        // start together with annul in IDLE is ignored.
        bus.start = 1'b1;
        bus.annul = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.annul = 1'b0;
        expect_quiet("annul_idle_quiet", 40);

        // Reset in the middle of an operation.
        bus.opdata1 = 32'd999;
        bus.opdata2 = 32'd9;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_ready", 2*W'(bus.ready), '0);
        check("midrst_result", bus.result, '0);
        expect_quiet("midrst_quiet", 40);
        run_op("after_rst", 1'b1, 32'hFFFF_FF00, 32'd16);

        // Back-to-back with start held high through the ready cycle.
        exp_a          = ref_div(1'b0, 32'd12345, 32'd67);
        exp_b          = ref_div(1'b1, 32'hFFFF_F000, 32'd10);
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd12345;
        bus.opdata2    = 32'd67;
        bus.start      = 1'b1;
        tick();
        bus.signed_div = 1'b1;
        bus.opdata1    = 32'hFFFF_F000;
        bus.opdata2    = 32'd10;
        wait_ready(n);
        check("b2b_first_latency", 2*W'(n), 2*W'(LATENCY));
        check("b2b_first_result", bus.result, exp_a);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ready && n < 200);
        bus.start = 1'b0;
        check("b2b_interval", 2*W'(n), 2*W'(W + 2));
        check("b2b_second_result", bus.result, exp_b);
        tick();
        check("b2b_second_pulse", 2*W'(bus.ready), '0);

        // MDU-style handshake: start = ~ready, operands changed after the sampling edge.
        exp_a          = ref_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        exp_b          = ref_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        bus.signed_div = 1'b1;
        bus.opdata1    = 32'hFFFF_FF9C;
        bus.opdata2    = 32'd7;
        bus.start      = 1'b1;
        tick();
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'hDEAD_BEEF;
        bus.opdata2    = 32'h0000_1234;
        n = 0;
        while (!bus.ready && n < 200) begin
            tick();
            n++;
            bus.start = ~bus.ready;
        end
        check("mdu_first_latency", 2*W'(n), 2*W'(LATENCY));
        check("mdu_first_result", bus.result, exp_a);
        n = 0;
        do begin
            tick();
            n++;
            bus.start = ~bus.ready;
        end while (!bus.ready && n < 200);
        bus.start = 1'b0;
        check("mdu_interval", 2*W'(n), 2*W'(W + 3));
        check("mdu_second_result", bus.result, exp_b);
        tick();
        check("mdu_second_pulse", 2*W'(bus.ready), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
